// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : Architectural register file with per-register rename tags,
//            commit bypass and ROB operand forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     rename_en,
    input  logic [REG_ID_BIT-1:0]    rename_rd,
    input  logic [ROB_WIDTH_BIT-1:0] rename_tag,
    input  logic [REG_ID_BIT-1:0]    rs1_id,
    input  logic [REG_ID_BIT-1:0]    rs2_id,
    output logic                     rs1_ready,
    output logic                     rs2_ready,
    output logic [31:0]              rs1_value,
    output logic [31:0]              rs2_value,
    output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
    output logic [ROB_WIDTH_BIT-1:0] rs2_dep,
    output logic [ROB_WIDTH_BIT-1:0] rob_query1,
    output logic [ROB_WIDTH_BIT-1:0] rob_query2,
    input  logic                     rob_rs1_ready,
    input  logic                     rob_rs2_ready,
    input  logic [31:0]              rob_rs1_value,
    input  logic [31:0]              rob_rs2_value,
    input  logic                     commit_en,
    input  logic [REG_ID_BIT-1:0]    commit_rd,
    input  logic [ROB_WIDTH_BIT-1:0] commit_tag,
    input  logic [31:0]              commit_value,
    input  logic                     clear_all
);

    localparam int c_NUM_REGS = 1 << REG_ID_BIT;

    logic [31:0]              r_value [c_NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] r_tag   [c_NUM_REGS];
    logic [c_NUM_REGS-1:0]    r_busy;

    logic [1:0][REG_ID_BIT-1:0]    w_id;
    logic [1:0]                    w_rob_ready;
    logic [1:0][31:0]              w_rob_value;
    logic [1:0]                    w_ready;
    logic [1:0][31:0]              w_val;
    logic [1:0][ROB_WIDTH_BIT-1:0] w_dep;
    logic [1:0][ROB_WIDTH_BIT-1:0] w_query;
    logic                          w_commit_ok;
    logic                          w_rename_ok;
    logic                          w_commit_frees;

    assign w_id[0]        = rs1_id;
    assign w_id[1]        = rs2_id;
    assign w_rob_ready[0] = rob_rs1_ready;
    assign w_rob_ready[1] = rob_rs2_ready;
    assign w_rob_value[0] = rob_rs1_value;
    assign w_rob_value[1] = rob_rs2_value;

    // Read ports see only pre-edge state; a same-cycle rename is invisible.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_ready[p] = 1'b1;
            w_val[p]   = '0;
            w_dep[p]   = '0;
            w_query[p] = r_tag[w_id[p]];
            if (w_id[p] == '0) begin
                w_query[p] = '0;
            end else if (!r_busy[w_id[p]]) begin
                w_val[p] = r_value[w_id[p]];
            end else if (commit_en && (commit_tag == r_tag[w_id[p]])) begin
                w_val[p] = commit_value;
            end else if (w_rob_ready[p]) begin
                w_val[p] = w_rob_value[p];
            end else begin
                w_ready[p] = 1'b0;
                w_dep[p]   = r_tag[w_id[p]];
            end
        end
    end

    assign rs1_ready  = w_ready[0];
    assign rs2_ready  = w_ready[1];
    assign rs1_value  = w_val[0];
    assign rs2_value  = w_val[1];
    assign rs1_dep    = w_dep[0];
    assign rs2_dep    = w_dep[1];
    assign rob_query1 = w_query[0];
    assign rob_query2 = w_query[1];

    assign w_commit_ok = commit_en && (commit_rd != '0);
    assign w_rename_ok = rename_en && (rename_rd != '0);
    // A same-cycle rename of the committed register means a younger owner.
    assign w_commit_frees = w_commit_ok && (r_tag[commit_rd] == commit_tag) &&
                            !(w_rename_ok && (rename_rd == commit_rd));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy <= '0;
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (w_commit_ok) begin
                r_value[commit_rd] <= commit_value;
            end
            if (clear_all) begin
                r_busy <= '0;
                for (int i = 0; i < c_NUM_REGS; i++) begin
                    r_tag[i] <= '0;
                end
            end else begin
                if (w_commit_frees) begin
                    r_busy[commit_rd] <= 1'b0;
                end
                if (w_rename_ok) begin
                    r_busy[rename_rd] <= 1'b1;
                    r_tag[rename_rd]  <= rename_tag;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Directed self-checking bench for reg_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        rename_en;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_tag;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        rs1_ready;
    logic        rs2_ready;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [3:0]  rs1_dep;
    logic [3:0]  rs2_dep;
    logic [3:0]  rob_query1;
    logic [3:0]  rob_query2;
    logic        rob_rs1_ready;
    logic        rob_rs2_ready;
    logic [31:0] rob_rs1_value;
    logic [31:0] rob_rs2_value;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_value;
    logic        clear_all;

    int n_vec;
    int n_miss;

    reg_file #(.REG_ID_BIT(5), .ROB_WIDTH_BIT(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .rename_en     (rename_en),
        .rename_rd     (rename_rd),
        .rename_tag    (rename_tag),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_ready     (rs1_ready),
        .rs2_ready     (rs2_ready),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
        .rs1_dep       (rs1_dep),
        .rs2_dep       (rs2_dep),
        .rob_query1    (rob_query1),
        .rob_query2    (rob_query2),
        .rob_rs1_ready (rob_rs1_ready),
        .rob_rs2_ready (rob_rs2_ready),
        .rob_rs1_value (rob_rs1_value),
        .rob_rs2_value (rob_rs2_value),
        .commit_en     (commit_en),
        .commit_rd     (commit_rd),
        .commit_tag    (commit_tag),
        .commit_value  (commit_value),
        .clear_all     (clear_all)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow later.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] tg);
        rename_en = 1'b1; rename_rd = rd; rename_tag = tg;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tg, input logic [31:0] v);
        commit_en = 1'b1; commit_rd = rd; commit_tag = tg; commit_value = v;
    endtask

    task automatic idle();
        rename_en = 1'b0; commit_en = 1'b0; clear_all = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_v [1:8];
        n_vec = 0; n_miss = 0;
        rst_in = 1'b1; rdy_in = 1'b1; idle();
        rename_rd = '0; rename_tag = '0; commit_rd = '0; commit_tag = '0; commit_value = '0;
        rs1_id = 5'd5; rs2_id = 5'd0;
        rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0; rob_rs1_value = '0; rob_rs2_value = '0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        #1;
        chk("rst_rs1_ready", rs1_ready, 1);
        chk("rst_rs1_value", rs1_value, 0);
        chk("rst_rs1_dep",   rs1_dep, 0);
        chk("rst_rs2_ready", rs2_ready, 1);
        chk("rst_rs2_value", rs2_value, 0);
        chk("rst_query1",    rob_query1, 0);

        // Rename x3 -> tag 7, then ROB forwarding.
        step(); rename(5'd3, 4'd7);
        step(); idle();
        rs1_id = 5'd3; rs2_id = 5'd3;
        rob_rs2_ready = 1'b1; rob_rs2_value = 32'h5678;
        #1;
        chk("x3_busy_ready", rs1_ready, 0);
        chk("x3_busy_dep",   rs1_dep, 7);
        chk("x3_busy_value", rs1_value, 0);
        chk("x3_query1",     rob_query1, 7);
        chk("x3_rob2_value", rs2_value, 32'h5678);
        chk("x3_rob2_dep",   rs2_dep, 0);
        rob_rs1_ready = 1'b1; rob_rs1_value = 32'h1234;
        #1;
        chk("x3_rob1_ready", rs1_ready, 1);
        chk("x3_rob1_value", rs1_value, 32'h1234);
        rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0;

        // Commit bypass then array hit.
        commit(5'd3, 4'd7, 32'hAB);
        #1;
        chk("x3_byp_ready", rs1_ready, 1);
        chk("x3_byp_value", rs1_value, 32'hAB);
        step(); idle();
        #1;
        chk("x3_arr_ready", rs1_ready, 1);
        chk("x3_arr_value", rs1_value, 32'hAB);

        // Stale commit must not free a register owned by a younger writer.
        rename(5'd4, 4'd2);
        step(); rename(5'd4, 4'd9);
        step(); idle(); commit(5'd4, 4'd2, 32'd5);
        step(); idle();
        rs1_id = 5'd4;
        #1;
        chk("x4_stale_ready", rs1_ready, 0);
        chk("x4_stale_dep",   rs1_dep, 9);
        commit(5'd4, 4'd9, 32'd6);
        #1;
        chk("x4_byp_value", rs1_value, 6);
        step(); idle();
        #1;
        chk("x4_arr_ready", rs1_ready, 1);
        chk("x4_arr_value", rs1_value, 6);

        // Rename wins over same-cycle commit of same register.
        rename(5'd6, 4'd1);
        step(); rename(5'd6, 4'd3); commit(5'd6, 4'd1, 32'h66);
        step(); idle();
        rs1_id = 5'd6;
        #1;
        chk("x6_ready", rs1_ready, 0);
        chk("x6_dep",   rs1_dep, 3);

        // x0 writes are ignored.
        rename(5'd0, 4'd5); commit(5'd0, 4'd5, 32'hFF);
        step(); idle();
        rs2_id = 5'd0;
        #1;
        chk("x0_ready", rs2_ready, 1);
        chk("x0_value", rs2_value, 0);
        chk("x0_dep",   rs2_dep, 0);
        chk("x0_query", rob_query2, 0);

        // Rename x1..x8, flush with concurrent rename x9 and commit x2.
        for (int r = 1; r <= 8; r++) begin
            rename(r[4:0], r[3:0]);
            step();
        end
        idle();
        clear_all = 1'b1; rename(5'd9, 4'd10); commit(5'd2, 4'd2, 32'h22);
        step(); idle();
        exp_v[1] = 0; exp_v[2] = 32'h22; exp_v[3] = 32'hAB; exp_v[4] = 6;
        exp_v[5] = 0; exp_v[6] = 32'h66; exp_v[7] = 0;    exp_v[8] = 0;
        for (int r = 1; r <= 8; r++) begin
            rs1_id = r[4:0];
            #1;
            chk($sformatf("flush_x%0d_ready", r), rs1_ready, 1);
            chk($sformatf("flush_x%0d_value", r), rs1_value, exp_v[r]);
        end
        rs2_id = 5'd9;
        #1;
        chk("flush_x9_ready", rs2_ready, 1);
        chk("flush_x9_query", rob_query2, 0);

        // Stall: rename and commit ignored while rdy_in is low.
        step();
        rdy_in = 1'b0; rename(5'd5, 4'd4); commit(5'd3, 4'd0, 32'h99);
        step(); idle(); rdy_in = 1'b1;
        rs1_id = 5'd5; rs2_id = 5'd3;
        #1;
        chk("stall_x5_ready", rs1_ready, 1);
        chk("stall_x3_value", rs2_value, 32'hAB);

        // Async reset mid-cycle.
        rename(5'd7, 4'd5);
        step(); idle();
        rs1_id = 5'd7;
        #1;
        chk("pre_rst_x7_dep", rs1_dep, 5);
        rst_in = 1'b1;
        #1;
        chk("async_x7_ready", rs1_ready, 1);
        chk("async_x7_dep",   rs1_dep, 0);
        chk("async_x3_value", rs2_value, 0);
        rst_in = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
